// File: rtl/neg_share_pkg.sv
// Shared definitions for the neg_share_arbiter block.
//   state_t   : arbiter/negation FSM states
//   NEG_WIDTH : default operand width
//   NEG_NREQ  : default number of requesters
//   neg_tc()  : two's-complement negation on a 32-bit container; callers keep
//               only the low WIDTH bits, which are exact for any WIDTH <= 31.
package neg_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int NEG_WIDTH = 4;
  localparam int NEG_NREQ  = 4;

  function automatic logic [31:0] neg_tc(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/neg_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : per-requester request vector
//   ptr       : highest-priority requester index for this search
//   grant     : one-hot grant (all zero when nothing is requested)
//   grant_idx : binary index of the granted requester (0 when no grant)
// The search starts at ptr and wraps from N_REQ-1 back to 0.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_idx
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/neg_share_arbiter.sv
// Round-robin front end for a single shared two's-complement negation unit.
// One request is accepted at a time: its operand and id are captured, negated
// in the following cycle, and the result is held until the consumer takes it.
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : synchronous reset, active-low
//   req_valid  : per-requester request valid
//   req_data   : operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready  : one-hot accept strobe (zero outside IDLE or in reset)
//   rsp_valid  : result valid, held until rsp_ready
//   rsp_ready  : consumer accepts result
//   rsp_data   : negated operand, mod 2^WIDTH
//   rsp_id     : requester that owns rsp_data
//   rsp_ovf    : (only with NEG_SHARE_OVF_EN) operand was the most-negative value
//
// Build option: define NEG_SHARE_OVF_EN to add the rsp_ovf output.
module neg_share_arbiter
  import neg_share_pkg::*;
#(
  parameter int N_REQ = NEG_NREQ,
  parameter int WIDTH = NEG_WIDTH,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
`ifdef NEG_SHARE_OVF_EN
  output logic                   rsp_ovf,
`endif
  output logic [IDW-1:0]         rsp_id
);

  localparam logic [IDW-1:0]   LAST_ID  = IDW'(N_REQ - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t            state;
  logic [IDW-1:0]    rr_ptr;
  logic [WIDTH-1:0]  op_p0;
  logic [IDW-1:0]    id_p0;
  logic [N_REQ-1:0]  grant;
  logic [IDW-1:0]    grant_idx;
  logic [31:0]       neg_full;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grants are only offered while idle and out of reset, so a nonzero
  // req_ready is itself the handshake (grant implies req_valid).
  assign req_ready = (rst_n && state == IDLE) ? grant : '0;

  assign neg_full = neg_tc({{(32-WIDTH){1'b0}}, op_p0});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_p0     <= '0;
      id_p0     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
`ifdef NEG_SHARE_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        // p0: capture the granted operand and id
        IDLE: begin
          if (|grant) begin
            op_p0  <= req_data[grant_idx*WIDTH +: WIDTH];
            id_p0  <= grant_idx;
            rr_ptr <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
            state  <= CALC;
          end
        end
        // p1: negate and register the response
        CALC: begin
          rsp_data  <= neg_full[WIDTH-1:0];
          rsp_id    <= id_p0;
          rsp_valid <= 1'b1;
`ifdef NEG_SHARE_OVF_EN
          rsp_ovf   <= (op_p0 == MOST_NEG);
`endif
          state     <= RESP;
        end
        // p2: hold the response until the consumer takes it
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neg_share_arbiter.sv
module tb_neg_share_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;
  localparam int MOD   = 1 << WIDTH;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ*WIDTH-1:0] req_data = '0;
  logic [N_REQ-1:0]       req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b0;
  logic [WIDTH-1:0]       rsp_data;
  logic [IDW-1:0]         rsp_id;
`ifdef NEG_SHARE_OVF_EN
  logic                   rsp_ovf;
`endif

  neg_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
`ifdef NEG_SHARE_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int data;
    int ovf;
  } exp_t;

  exp_t             exp_q[$];
  int               n_vec = 0;
  int               n_fail = 0;
  int               cyc = 0;
  int               grant_cyc = 0;
  bit               outstanding = 1'b0;
  int               rr = 0;
  bit               pend[N_REQ];
  logic [WIDTH-1:0] pdata[N_REQ];
  bit               prev_vld = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] pick();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(7))
      0: return '0;
      1: return {1'b1, {(WIDTH-1){1'b0}}};
      2: return '1;
      3: return {1'b0, {(WIDTH-1){1'b1}}};
      default: return r[WIDTH-1:0];
    endcase
  endfunction

  // Reference: the first pending requester at or after the pointer, wrapping.
  function automatic int winner();
    for (int k = 0; k < N_REQ; k++) begin
      if (pend[(rr + k) % N_REQ]) return (rr + k) % N_REQ;
    end
    return -1;
  endfunction

  // One clock of stimulus. Probabilities in percent, except p_rst in per-mille.
  task automatic cycle(input int p_new, input int p_drop, input int p_rdy, input int p_rst);
    int w;
    int d;
    logic [N_REQ-1:0] exp_ready;
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (!rst_n) begin
      exp_q.delete();
      outstanding = 1'b0;
      rr = 0;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
`ifdef NEG_SHARE_OVF_EN
      check("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
`endif
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (pend[i]) begin
        if (int'($urandom_range(99)) < p_drop) pend[i] = 1'b0;
      end else if (int'($urandom_range(99)) < p_new) begin
        pend[i]  = 1'b1;
        pdata[i] = pick();
      end
    end
    rsp_ready = (int'($urandom_range(99)) < p_rdy);
    rst_n     = !(int'($urandom_range(999)) < p_rst);
    for (int i = 0; i < N_REQ; i++) begin
      req_valid[i] = pend[i];
      req_data[i*WIDTH +: WIDTH] = pdata[i];
    end
    #1;
    w = winner();
    exp_ready = '0;
    if (rst_n && !outstanding && w >= 0) exp_ready[w] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    if (rst_n && !outstanding && w >= 0) begin
      d = int'(pdata[w]);
      e.id   = w;
      e.data = (MOD - d) % MOD;
      e.ovf  = (d == MOD / 2) ? 1 : 0;
      exp_q.push_back(e);
      outstanding = 1'b1;
      grant_cyc = cyc;
      rr = (w + 1) % N_REQ;
      pend[w] = 1'b0;
    end
  endtask

  // Monitor: compares the presented response against the queue head every
  // cycle it is valid (so it must stay stable under backpressure), pops on
  // consumption, and checks response latency.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (!prev_vld) check("rsp_latency", 32'(cyc - grant_cyc), 32'd2);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d data=%0d expected no response (cycle %0d)",
                 rsp_id, rsp_data, cyc);
      end else begin
        check("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
        check("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
`ifdef NEG_SHARE_OVF_EN
        check("rsp_ovf", 32'(rsp_ovf), 32'(exp_q[0].ovf));
`endif
        if (rst_n && rsp_ready) begin
          void'(exp_q.pop_front());
          outstanding = 1'b0;
        end
      end
    end else if (outstanding && (cyc - grant_cyc) >= 2) begin
      check("rsp_pending", 32'(rsp_valid), 32'd1);
    end
    prev_vld = rsp_valid;
  end

  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      pend[i]  = 1'b0;
      pdata[i] = '0;
    end
    rst_n = 1'b0;
    // Reset held for two edges; cycle() checks reset values after each.
    cycle(0, 0, 0, 1000);
    cycle(0, 0, 0, 0);
    check("idle_ready", 32'(req_ready), 32'd0);

    // Single request from requester 2 with operand 0011.
    pend[2] = 1'b1; pdata[2] = 4'b0011;
    repeat (5) cycle(0, 0, 100, 0);

    // Boundary operands, all requesters held valid, zero-wait consumer.
    pend[0] = 1'b1; pdata[0] = 4'b0000;
    pend[1] = 1'b1; pdata[1] = 4'b1000;
    pend[2] = 1'b1; pdata[2] = 4'b1111;
    pend[3] = 1'b1; pdata[3] = 4'b0111;
    repeat (14) cycle(0, 0, 100, 0);

    // Backpressure: consumer stalls while all requesters wait.
    for (int i = 0; i < N_REQ; i++) begin pend[i] = 1'b1; pdata[i] = pick(); end
    repeat (8) cycle(0, 0, 0, 0);
    repeat (4) cycle(0, 0, 100, 0);

    // Reset during CALC: grant requester 2, then reset; requester 0 wins after.
    repeat (12) cycle(0, 0, 100, 0);
    for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
    repeat (3) cycle(0, 0, 100, 0);
    pend[2] = 1'b1; pdata[2] = 4'b0101;
    cycle(0, 0, 100, 0);
    for (int i = 0; i < N_REQ; i++) begin pend[i] = 1'b1; pdata[i] = pick(); end
    cycle(0, 0, 100, 1000);
    repeat (6) cycle(0, 0, 100, 0);
    for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
    repeat (14) cycle(0, 0, 100, 0);

    // Pointer wrap: only requester 3, then requesters 0 and 3.
    pend[3] = 1'b1; pdata[3] = 4'b0110;
    repeat (3) cycle(0, 0, 100, 0);
    pend[0] = 1'b1; pdata[0] = 4'b1010;
    pend[3] = 1'b1; pdata[3] = 4'b0001;
    repeat (8) cycle(0, 0, 100, 0);

    // Randomized traffic with drops, stalls and occasional resets.
    repeat (1500) cycle(40, 5, 60, 8);

    // Drain.
    for (int k = 0; k < N_REQ; k++) pend[k] = 1'b0;
    for (int k = 0; k < 20 && (outstanding || exp_q.size() != 0); k++) cycle(0, 0, 100, 0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
